// File: rtl/divider_8bit_seq.sv
// divider_8bit_seq
//   Sequential unsigned restoring divider. Produces one quotient bit per
//   clock by shift-and-subtract; a division takes WIDTH cycles in RUN,
//   followed by a one-cycle DONE pulse. Divide-by-zero skips RUN entirely.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, accepted only in IDLE or DONE
//   dividend     unsigned dividend, captured on the accepted start edge
//   divisor      unsigned divisor, captured on the accepted start edge
//   busy         high while iterating (state RUN)
//   done         one-cycle pulse, results valid (state DONE)
//   quotient     result quotient, held until the next done
//   remainder    result remainder, held until the next done
//   div_by_zero  set with done when divisor was 0, held until the next done
module divider_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    assign accept    = start && (state_q != RUN);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // One restoring step. R holds at most i dividend bits before step i,
    // so its MSB is always 0 here and {R, Q[MSB]} equals {1'b0, R'}.
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, d_q};
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_next = r_shift[WIDTH-1:0];
            q_next = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Working registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                q_q   <= dividend;
                r_q   <= '0;
                d_q   <= divisor;
                cnt_q <= '0;
            end
        end else if (state_q == RUN) begin
            q_q   <= q_next;
            r_q   <= r_next;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
                quotient    <= q_next;
                remainder   <= r_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// tb_divider_8bit_seq
//   Directed and random checks of divider_8bit_seq against a cycle-level
//   behavioural model built on the / and % operators.
module tb_divider_8bit_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    divider_8bit_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run_left counts the busy cycles still to come.
    int               run_left = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    logic             m_z = 1'b0;
    int               pend_q = 0;
    int               pend_r = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_left = 0;
            m_done   = 1'b0;
            m_q      = '0;
            m_r      = '0;
            m_z      = 1'b0;
        end else begin
            m_done = 1'b0;
            if (run_left > 0) begin
                run_left--;
                if (run_left == 0) begin
                    m_done = 1'b1;
                    m_q    = WIDTH'(pend_q);
                    m_r    = WIDTH'(pend_r);
                    m_z    = 1'b0;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_done = 1'b1;
                    m_q    = '1;
                    m_r    = dividend;
                    m_z    = 1'b1;
                end else begin
                    run_left = WIDTH;
                    pend_q   = int'(dividend) / int'(divisor);
                    pend_r   = int'(dividend) % int'(divisor);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy", {31'b0, busy}, {31'b0, run_left > 0});
        check("done", {31'b0, done}, {31'b0, m_done});
        check("quotient", {24'b0, quotient}, {24'b0, m_q});
        check("remainder", {24'b0, remainder}, {24'b0, m_r});
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_z});
    end

    // Waits for done, counting negedges from cyc_in; clears start after the
    // first edge unless hold is set.
    task automatic wait_done(input int cyc_in, input bit hold, output int cyc);
        cyc = cyc_in;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
        end while (!done && cyc < 40);
    endtask

    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic ez, input string name);
        int cyc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        wait_done(0, 1'b0, cyc);
        check({name, " latency"}, cyc, (b == 0) ? 1 : WIDTH + 1);
        check({name, " q"}, {24'b0, quotient}, {24'b0, eq});
        check({name, " r"}, {24'b0, remainder}, {24'b0, er});
        check({name, " dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int t1;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset q", {24'b0, quotient}, 32'd0);
        check("reset r", {24'b0, remainder}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "200/7");
        run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "255/1");
        run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "255/255");
        run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "5/9");
        run_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, "0/3");
        run_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, "77/0");
        run_div(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, "10/3");

        // Start re-pulsed at E3 with other operands must be ignored.
        dividend = 8'd100;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        wait_done(3, 1'b0, cyc);
        check("ignored start latency", cyc, WIDTH + 1);
        check("ignored start q", {24'b0, quotient}, 32'd11);
        check("ignored start r", {24'b0, remainder}, 32'd1);

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        check("busy before abort", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort q", {24'b0, quotient}, 32'd0);
        check("abort r", {24'b0, remainder}, 32'd0);
        check("abort dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, "9/2 after reset");

        // Back-to-back with start held high.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        wait_done(0, 1'b1, t1);
        check("b2b first q", {24'b0, quotient}, 32'd28);
        check("b2b first r", {24'b0, remainder}, 32'd4);
        dividend = 8'd13;
        divisor  = 8'd4;
        wait_done(0, 1'b1, cyc);
        start = 1'b0;
        check("b2b spacing", cyc, WIDTH + 1);
        check("b2b second q", {24'b0, quotient}, 32'd3);
        check("b2b second r", {24'b0, remainder}, 32'd1);

        // Random sweep, with a divisor of zero mixed in now and then.
        for (int i = 0; i < 16; i++) begin
            a = WIDTH'($urandom_range(0, 255));
            b = (i % 5 == 4) ? '0 : WIDTH'($urandom_range(1, 255));
            if (b == 0) begin
                run_div(a, b, '1, a, 1'b1, "random");
            end else begin
                run_div(a, b, WIDTH'(int'(a) / int'(b)), WIDTH'(int'(a) % int'(b)), 1'b0, "random");
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/divider_8bit_seq.md
# divider_8bit_seq

Sequential unsigned restoring divider: the inverse companion to the team's 8-bit adder/subtractor datapath. It computes quotient and remainder of two WIDTH-bit unsigned operands by repeated shift-and-subtract, one quotient bit per clock. It sits beside the add/sub unit in the arithmetic block and is driven by a start/done handshake from the controlling logic.

## Interface
- WIDTH, 8: operand, quotient and remainder width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled on rising clk edge.
- dividend  input  WIDTH  unsigned dividend; sampled only on the accepted start edge.
- divisor  input  WIDTH  unsigned divisor; sampled only on the accepted start edge.
- busy  output  1  high while an accepted division is iterating (state RUN).
- done  output  1  one-cycle pulse: quotient/remainder/div_by_zero are valid.
- quotient  output  WIDTH  result quotient; holds until the next done.
- remainder  output  WIDTH  result remainder; holds until the next done.
- div_by_zero  output  1  set with done when divisor was 0; holds until the next done.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Start is accepted only in IDLE or DONE. Start in RUN is ignored; it is neither queued nor allowed to corrupt the operation.
- On an accepted start with divisor ≠ 0:
  - Latch the operands into an internal working quotient register Q (= dividend), a remainder register R (WIDTH bits, = 0), a divisor register D, and a counter (= 0).
  - Go to RUN.
- On an accepted start with divisor = 0:
  - Go directly to DONE.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN iteration, once per clk:
  - {R', Q'} = {R, Q} << 1.
  - Trial T = {1'b0, R'} − {1'b0, D}, computed at WIDTH+1 bits.
  - If T[WIDTH] = 0 (no borrow): R = T[WIDTH-1:0] and Q = {Q'[WIDTH-1:1], 1}.
  - Otherwise: R = R' and Q = {Q'[WIDTH-1:1], 0}.
  - Counter increments.
- After the WIDTH-th iteration:
  - Transfer Q → quotient and R → remainder.
  - Clear div_by_zero.
  - Go to DONE.
- DONE lasts one cycle. It then returns to IDLE unless a new start is accepted, in which case it goes to RUN, or to DONE for divisor = 0.
- Result outputs change only on entry to DONE. Internal working registers are never visible on the outputs.

## Timing
- Reset (asynchronous, immediate): state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, counter 0.
- Reset asserted mid-RUN aborts the division. All outputs go to their reset values and no done is produced.
- Cycle numbering: start is accepted at edge E0.
  - Normal division: busy = 1 from after E0 through E(WIDTH−1). At E(WIDTH), done = 1 with valid results and busy = 0. At E(WIDTH+1), done = 0. Latency from start edge to done is WIDTH+… stated precisely: done is high during the cycle following edge E(WIDTH), i.e. WIDTH cycles after acceptance.
  - Divide by zero: done = 1 after E0 for one cycle; busy never rises.
- busy = 1 exactly when state = RUN. done = 1 exactly when state = DONE. The two are never high together.
- Back-to-back: start held high during the DONE cycle is accepted at the next edge, so successive done pulses are WIDTH+1 cycles apart.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then dividend = 200, divisor = 7, 1-cycle start -> busy high for 8 cycles; done pulse with quotient = 28, remainder = 4, div_by_zero = 0 at E8.
- Edge operands, WIDTH = 8:
  - 255/1 -> quotient 255, remainder 0.
  - 255/255 -> quotient 1, remainder 0.
  - 5/9 -> quotient 0, remainder 5.
  - 0/3 -> quotient 0, remainder 0.
- 77/0 -> done one cycle after start; quotient 0xFF, remainder 77, div_by_zero 1; busy stays 0. A following 10/3 clears div_by_zero (quotient 3, remainder 1).
- Start pulsed again at E3 of a 100/9 operation with different operands (50/5) -> ignored; result is quotient 11, remainder 1.
- rst asserted asynchronously mid-RUN (between edges, at E4) -> outputs cleared immediately, no done; a following 9/2 completes normally with quotient 4, remainder 1.
- Start held high continuously with 200/7, then 13/4 -> done pulses exactly 9 cycles apart with results 28/4, then 3/1; random-operand sweep checked against a reference model of / and %.
